// File: rtl/frac_clk_div.sv
// Programmable clock divider: divide by N or N+0.5 with a near-50% duty cycle.
// Config changes and stops take effect only at counter-cycle boundaries.
module frac_clk_div #(
  parameter int CNT_W        = 8,
  parameter int RST_DIV_INT  = 3,
  parameter bit RST_DIV_HALF = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] div_int,
  input  logic             div_half,
  output logic             clk_out,
  output logic             running,
  output logic             cycle_tick,
  output logic             cfg_pending
);
  localparam int CW = CNT_W + 1;
  localparam logic [CNT_W-1:0] RST_N = CNT_W'(RST_DIV_HALF ? ((RST_DIV_INT < 1) ? 1 : RST_DIV_INT)
                                                         : ((RST_DIV_INT < 2) ? 2 : RST_DIV_INT));

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_n, w_n_nxt, r_pend_n;
  logic             r_half, w_half_nxt, r_pend_half, r_pend, w_pend_nxt;
  logic             r_hi_p, w_hi_p_nxt, r_hi_n, w_hi_n;
  logic             r_tick, w_tick_nxt, w_wrap, w_apply;
  logic [CW-1:0]    w_len, w_nb, w_hl;

  function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] n, input logic half);
    logic [CNT_W-1:0] lo;
    lo = half ? CNT_W'(1) : CNT_W'(2);
    return (n < lo) ? lo : n;
  endfunction

  // Length of the first high phase: ceil(N/2) in half mode, floor(N/2) otherwise.
  function automatic logic [CW-1:0] hi_len(input logic [CNT_W-1:0] n, input logic half);
    return half ? CW'(({1'b0, n} + CW'(1)) >> 1) : CW'(n >> 1);
  endfunction

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;

  always_comb begin
    w_len       = r_half ? {r_n, 1'b1} : {1'b0, r_n};
    w_wrap      = (r_state == S_RUN) && (r_cnt == w_len - CW'(1));
    w_apply     = r_pend && ((r_state != S_RUN) || w_wrap);
    w_n_nxt     = w_apply ? clamp_n(r_pend_n, r_pend_half) : r_n;
    w_half_nxt  = w_apply ? r_pend_half : r_half;
    w_pend_nxt  = r_pend;
    if (w_apply)  w_pend_nxt = 1'b0;
    if (cfg_load) w_pend_nxt = 1'b1;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    case (r_state)
      S_IDLE: if (en) w_state_nxt = S_ARM;
      S_ARM: begin
        w_state_nxt = S_RUN;
        w_tick_nxt  = 1'b1;
      end
      S_RUN: begin
        if (w_wrap) begin
          w_cnt_nxt = '0;
          if (en) w_tick_nxt  = 1'b1;
          else    w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Posedge-aligned high phase, computed from the config that is live next cycle.
    w_hi_p_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt < hi_len(w_n_nxt, w_half_nxt));
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_cnt       <= '0;
      r_n         <= RST_N;
      r_half      <= RST_DIV_HALF;
      r_pend_n    <= '0;
      r_pend_half <= 1'b0;
      r_pend      <= 1'b0;
      r_hi_p      <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_n    <= w_n_nxt;
      r_half <= w_half_nxt;
      r_pend <= w_pend_nxt;
      r_hi_p <= w_hi_p_nxt;
      r_tick <= w_tick_nxt;
      if (cfg_load) begin
        r_pend_n    <= div_int;
        r_pend_half <= div_half;
      end
    end

  // Negedge term spans [c+0.5, c+1.5): extends an odd integer high phase by half
  // a clk, or forms the whole second pulse in half mode. r_cnt is stable here.
  always_comb begin
    w_nb   = {1'b0, r_n};
    w_hl   = hi_len(r_n, r_half);
    w_hi_n = (r_state == S_RUN) &&
             (r_half ? ((r_cnt >= w_nb) && (r_cnt < w_nb + w_hl))
                     : (r_n[0] && (r_cnt == w_hl - CW'(1))));
  end

  always_ff @(negedge clk or negedge rstn)
    if (!rstn) r_hi_n <= 1'b0;
    else       r_hi_n <= w_hi_n;

  assign clk_out     = r_hi_p | r_hi_n;
  assign running     = (r_state != S_IDLE);
  assign cycle_tick  = r_tick;
  assign cfg_pending = r_pend;
endmodule

// File: tb/tb_frac_clk_div.sv
// Scoreboard bench for frac_clk_div: expected clk_out edges (level, preceding
// segment length in half-clk units, cycle_tick on rises) are queued by stimulus.
module tb_frac_clk_div;
  logic       clk, rstn, en, cfg_load, div_half;
  logic [7:0] div_int;
  logic       clk_out, running, cycle_tick, cfg_pending;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit lvl;
    int dur;  // 0 = length not checked (first rise after idle, reset fall)
    bit tk;
  } ev_t;
  ev_t    q[$];
  bit     mon_en = 1'b0;
  longint t_last = 0;

  typedef struct {
    int n;
    bit h;
    int hi;
    int lo;
    int len;
  } vec_t;
  vec_t tbl[8] = '{
    '{4, 1'b0, 4, 4, 4},
    '{5, 1'b0, 5, 5, 5},
    '{1, 1'b1, 2, 1, 3},
    '{2, 1'b1, 2, 3, 5},
    '{4, 1'b1, 4, 5, 9},
    '{7, 1'b1, 8, 7, 15},
    '{0, 1'b0, 2, 2, 2},
    '{0, 1'b1, 2, 1, 3}
  };

  frac_clk_div #(.CNT_W(8), .RST_DIV_INT(3), .RST_DIV_HALF(1'b1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_load(cfg_load),
    .div_int(div_int), .div_half(div_half),
    .clk_out(clk_out), .running(running), .cycle_tick(cycle_tick), .cfg_pending(cfg_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: every clk_out edge is matched against the head of the queue.
  always @(clk_out) begin
    ev_t e;
    int  d;
    d = int'(($time - t_last) / 5);
    t_last = $time;
    if (mon_en) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL edge_unexpected: clk_out became %0b at %0t, required no edge", clk_out, $time);
      end else begin
        e = q.pop_front();
        n_chk++;
        if (clk_out !== e.lvl) begin
          n_fail++;
          $display("FAIL edge_level: got %0b at %0t, expected %0b", clk_out, $time, e.lvl);
        end
        if (e.dur != 0) begin
          n_chk++;
          if (d != e.dur) begin
            n_fail++;
            $display("FAIL seg_len: got %0d half-clk before edge at %0t, expected %0d", d, $time, e.dur);
          end
        end
        if (e.lvl) begin
          #1;
          n_chk++;
          if (cycle_tick !== e.tk) begin
            n_fail++;
            $display("FAIL rise_tick: got %0b at %0t, expected %0b", cycle_tick, $time, e.tk);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b at %0t, expected %0b", nm, act, $time, exp);
    end
  endtask

  task automatic push(input bit lvl, input int dur, input bit tk);
    ev_t e;
    e.lvl = lvl; e.dur = dur; e.tk = tk;
    q.push_back(e);
  endtask

  task automatic push_cycle(input bit h, input int prev_lo, input int hi, input int lo);
    push(1'b1, prev_lo, 1'b1);
    push(1'b0, hi, 1'b0);
    if (h) begin
      push(1'b1, lo, 1'b0);
      push(1'b0, hi, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d edges still expected at %0t, expected 0", q.size(), $time);
      q.delete();
    end
  endtask

  // Idle load: pending for one cycle, then applied on the next posedge.
  task automatic load(input int n, input bit h);
    div_int = 8'(n); div_half = h; cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    chk("load_pending", cfg_pending, 1'b1);
    tick(1);
    chk("idle_apply", cfg_pending, 1'b0);
  endtask

  // Start, optionally blip en low mid first cycle, stop at t=1 of the last cycle.
  task automatic run(input int ncyc, input int len, input bit blip);
    en = 1'b1;
    tick(1);
    chk("start_running", running, 1'b1);
    chk("start_latency", clk_out, 1'b0);
    tick(1);
    chk("first_rise", clk_out, 1'b1);
    chk("first_tick", cycle_tick, 1'b1);
    if (blip) begin
      tick(1); en = 1'b0;
      tick(1); en = 1'b1;
      tick(len * (ncyc - 1) - 1);
    end else begin
      tick(len * (ncyc - 1) + 1);
    end
    en = 1'b0;
    tick(len - 2);
    chk("before_stop", running, 1'b1);
    tick(1);
    chk("stopped", running, 1'b0);
    chk("stopped_low", clk_out, 1'b0);
    chk("stopped_tick", cycle_tick, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; cfg_load = 1'b0; div_int = 8'd3; div_half = 1'b1;
    tick(2);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_tick", cycle_tick, 1'b0);
    chk("rst_pending", cfg_pending, 1'b0);
    rstn = 1'b1;
    t_last = $time;
    mon_en = 1'b1;

    // Reset ratio 3.5 with an en blip that must not interrupt.
    push_cycle(1'b1, 0, 4, 3);
    push_cycle(1'b1, 3, 4, 3);
    run(2, 7, 1'b1);
    drain();

    // Integer even/odd, half-mode sweep, clamps.
    for (int i = 0; i < 8; i++) begin
      load(tbl[i].n, tbl[i].h);
      push_cycle(tbl[i].h, 0, tbl[i].hi, tbl[i].lo);
      push_cycle(tbl[i].h, tbl[i].lo, tbl[i].hi, tbl[i].lo);
      run(2, tbl[i].len, 1'b0);
      drain();
    end

    // Live change 3.5 -> 6 with a double load and an unloaded input change.
    load(3, 1'b1);
    push_cycle(1'b1, 0, 4, 3);
    push_cycle(1'b0, 3, 6, 6);
    push_cycle(1'b0, 6, 6, 6);
    en = 1'b1;
    tick(2);
    tick(2);
    div_int = 8'd9; div_half = 1'b0; cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    chk("live_pending_a", cfg_pending, 1'b1);
    tick(1);
    div_int = 8'd6; cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    div_int = 8'd2; div_half = 1'b1;
    tick(1);
    chk("live_pending_b", cfg_pending, 1'b1);
    tick(1);
    chk("live_switched", cfg_pending, 1'b0);
    tick(7);
    en = 1'b0;
    tick(4);
    chk("live_before_stop", running, 1'b1);
    tick(1);
    chk("live_stopped", running, 1'b0);
    chk("live_stopped_low", clk_out, 1'b0);
    drain();

    // Async reset while clk_out is high, then restart at the reset ratio.
    push(1'b1, 0, 1'b1);
    push(1'b0, 0, 1'b0);
    en = 1'b1;
    tick(2);
    chk("pre_reset_high", clk_out, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("async_clk_out", clk_out, 1'b0);
    chk("async_running", running, 1'b0);
    chk("async_tick", cycle_tick, 1'b0);
    en = 1'b0;
    #2 rstn = 1'b1;
    push_cycle(1'b1, 0, 4, 3);
    push_cycle(1'b1, 3, 4, 3);
    tick(1);
    run(2, 7, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
